// File: rtl/i2c_target_regfile.sv
// I2C target with a byte-wide register bank, auto-increment pointer and a local host port.
// Define I2C_CLK_STRETCH_EN to hold SCL low for STRETCH_CYCLES after each target-driven ACK.
module i2c_target_regfile #(
    parameter int unsigned NUM_REGS       = 16,
    parameter int unsigned PTR_W          = 4,
    parameter int unsigned STRETCH_CYCLES = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       chip_addr,
    input  logic             open_drain,
    input  logic             sda_in,
    output logic             sda_out,
    output logic             sda_oen,
    input  logic             scl_in,
    output logic             scl_out,
    output logic             scl_oen,
    input  logic             host_wr_en,
    input  logic [PTR_W-1:0] host_addr,
    input  logic [7:0]       host_wr_data,
    output logic [7:0]       host_rd_data,
    output logic             bus_wr_pulse,
    output logic [PTR_W-1:0] bus_wr_addr,
    output logic             busy,
    output logic             done
);

    typedef enum logic [3:0] {
        StIdle, StAddr, StAddrAck, StPtr, StPtrAck,
        StWdata, StWdataAck, StRdata, StRdataAck, StIgnore
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             ack_phase_q, ack_phase_d;
    logic             rw_q, rw_d;
    logic             drive_en_q, drive_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             wr_pulse_q, wr_pulse_d;
    logic [PTR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]       regs_q [NUM_REGS];
    logic [7:0]       regs_d [NUM_REGS];
    logic             stretch_load;
    logic [7:0]       byte_in;

    // [0],[1] synchronise, [2] holds the previous synced value for edge detection.
    logic [2:0] sda_sync_q, scl_sync_q;
    always_ff @(posedge clk) begin
        sda_sync_q <= {sda_sync_q[1:0], sda_in};
        scl_sync_q <= {scl_sync_q[1:0], scl_in};
    end

    logic sda_now, sda_prev, scl_now, scl_prev;
    logic scl_rise, scl_fall, start_det, stop_det;
    assign sda_now   = sda_sync_q[1];
    assign sda_prev  = sda_sync_q[2];
    assign scl_now   = scl_sync_q[1];
    assign scl_prev  = scl_sync_q[2];
    assign scl_rise  = scl_now & ~scl_prev;
    assign scl_fall  = ~scl_now & scl_prev;
    assign start_det = scl_now & scl_prev & sda_prev & ~sda_now;
    assign stop_det  = scl_now & scl_prev & ~sda_prev & sda_now;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        ptr_d        = ptr_q;
        ack_phase_d  = ack_phase_q;
        rw_d         = rw_q;
        drive_en_d   = drive_en_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        wr_pulse_d   = 1'b0;
        wr_addr_d    = wr_addr_q;
        regs_d       = regs_q;
        stretch_load = 1'b0;
        byte_in      = {shift_q[6:0], sda_now};

        if (host_wr_en) begin
            regs_d[host_addr] = host_wr_data;
        end

        if (stop_det) begin
            state_d    = StIdle;
            busy_d     = 1'b0;
            done_d     = busy_q;
            drive_en_d = 1'b0;
        end else if (start_det) begin
            state_d     = StAddr;
            bit_cnt_d   = 3'd0;
            ack_phase_d = 1'b0;
            drive_en_d  = 1'b0;
        end else begin
            unique case (state_q)
                StAddr, StPtr, StWdata: begin
                    if (scl_rise) begin
                        shift_d     = byte_in;
                        bit_cnt_d   = bit_cnt_q + 3'd1;
                        ack_phase_d = 1'b0;
                        if (bit_cnt_q == 3'd7) begin
                            if (state_q == StAddr) begin
                                if (byte_in[7:1] == chip_addr) begin
                                    state_d = StAddrAck;
                                    busy_d  = 1'b1;
                                    rw_d    = byte_in[0];
                                end else begin
                                    state_d = StIgnore;
                                end
                            end else if (state_q == StPtr) begin
                                ptr_d   = byte_in[PTR_W-1:0];
                                state_d = StPtrAck;
                            end else begin
                                // Assigned after the host write so the bus wins a collision.
                                regs_d[ptr_q] = byte_in;
                                wr_pulse_d    = 1'b1;
                                wr_addr_d     = ptr_q;
                                ptr_d         = ptr_q + PTR_W'(1);
                                state_d       = StWdataAck;
                            end
                        end
                    end
                end
                StAddrAck, StPtrAck, StWdataAck: begin
                    // First falling edge starts the ACK, the second one ends it.
                    if (scl_fall) begin
                        if (!ack_phase_q) begin
                            ack_phase_d = 1'b1;
                            drive_en_d  = 1'b1;
                        end else begin
                            ack_phase_d  = 1'b0;
                            bit_cnt_d    = 3'd0;
                            stretch_load = 1'b1;
                            if (state_q == StAddrAck && rw_q) begin
                                shift_d    = regs_q[ptr_q];
                                drive_en_d = 1'b1;
                                state_d    = StRdata;
                            end else begin
                                drive_en_d = 1'b0;
                                state_d    = (state_q == StAddrAck) ? StPtr : StWdata;
                            end
                        end
                    end
                end
                StRdata: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 3'd7) begin
                            drive_en_d  = 1'b0;
                            ptr_d       = ptr_q + PTR_W'(1);
                            ack_phase_d = 1'b0;
                            bit_cnt_d   = 3'd0;
                            state_d     = StRdataAck;
                        end else begin
                            shift_d   = {shift_q[6:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                StRdataAck: begin
                    if (scl_rise) begin
                        if (sda_now) begin
                            state_d = StIgnore;
                        end else begin
                            ack_phase_d = 1'b1;
                        end
                    end else if (scl_fall && ack_phase_q) begin
                        ack_phase_d = 1'b0;
                        bit_cnt_d   = 3'd0;
                        shift_d     = regs_q[ptr_q];
                        drive_en_d  = 1'b1;
                        state_d     = StRdata;
                    end
                end
                StIdle, StIgnore: begin
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            ptr_q       <= '0;
            ack_phase_q <= 1'b0;
            rw_q        <= 1'b0;
            drive_en_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_pulse_q  <= 1'b0;
            wr_addr_q   <= '0;
            regs_q      <= '{default: 8'h00};
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            ack_phase_q <= ack_phase_d;
            rw_q        <= rw_d;
            drive_en_q  <= drive_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            wr_pulse_q  <= wr_pulse_d;
            wr_addr_q   <= wr_addr_d;
            regs_q      <= regs_d;
        end
    end

    // Only read data can be a 1; every ACK drives 0.
    logic drive_bit;
    assign drive_bit    = (state_q == StRdata) ? shift_q[7] : 1'b0;
    assign sda_oen      = open_drain ? (drive_en_q & ~drive_bit) : drive_en_q;
    assign sda_out      = open_drain ? 1'b0 : drive_bit;
    assign scl_out      = 1'b0;
    assign host_rd_data = regs_q[host_addr];
    assign bus_wr_pulse = wr_pulse_q;
    assign bus_wr_addr  = wr_addr_q;
    assign busy         = busy_q;
    assign done         = done_q;

`ifdef I2C_CLK_STRETCH_EN
    localparam int unsigned SW = $clog2(STRETCH_CYCLES + 1);
    logic [SW-1:0] stretch_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            stretch_q <= '0;
        end else if (stretch_load) begin
            stretch_q <= SW'(STRETCH_CYCLES);
        end else if (stretch_q != '0) begin
            stretch_q <= stretch_q - SW'(1);
        end
    end
    assign scl_oen = (stretch_q != '0);
`else
    logic unused_stretch;
    assign unused_stretch = stretch_load ^ (STRETCH_CYCLES == 0);
    assign scl_oen = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Scoreboard bench for i2c_target_regfile: a bit-banged master plus a monitor that checks
// bus writes, read bytes and done pulses against queued expectations.
module tb_i2c_target_regfile;
    localparam int Q = 8;  // clk cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] chip_addr = 7'h50;
    logic       open_drain = 1'b1;
    logic       m_sda = 1'b1;
    logic       m_scl = 1'b1;
    logic       sda_bus, scl_bus;
    logic       sda_out, sda_oen, scl_out, scl_oen;
    logic       host_wr_en = 1'b0;
    logic [3:0] host_addr = 4'd0;
    logic [7:0] host_wr_data = 8'h00;
    logic [7:0] host_rd_data;
    logic       bus_wr_pulse;
    logic [3:0] bus_wr_addr;
    logic       busy, done;

    int n_vec = 0;
    int n_err = 0;
    logic [3:0] exp_wr[$];
    logic [7:0] exp_rd[$];
    int exp_done = 0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       watch_mm = 1'b0;
    int oen_seen = 0;
    int busy_seen = 0;
    int scl_oen_seen = 0;
    int stretch_run = 0;
    int stretch_runs[$];

    always #5 clk = ~clk;

    assign sda_bus = sda_oen ? (m_sda & sda_out) : m_sda;
    assign scl_bus = scl_oen ? (m_scl & scl_out) : m_scl;

    i2c_target_regfile #(
        .NUM_REGS(16),
        .PTR_W(4),
        .STRETCH_CYCLES(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .chip_addr(chip_addr),
        .open_drain(open_drain),
        .sda_in(sda_bus),
        .sda_out(sda_out),
        .sda_oen(sda_oen),
        .scl_in(scl_bus),
        .scl_out(scl_out),
        .scl_oen(scl_oen),
        .host_wr_en(host_wr_en),
        .host_addr(host_addr),
        .host_wr_data(host_wr_data),
        .host_rd_data(host_rd_data),
        .bus_wr_pulse(bus_wr_pulse),
        .bus_wr_addr(bus_wr_addr),
        .busy(busy),
        .done(done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: event seen with nothing expected", name);
    endtask

    task automatic wait_q(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic scl_up();
        int t;
        t = 0;
        m_scl = 1'b1;
        #1;
        while (scl_bus !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) unexpected("scl_release_timeout");
    endtask

    task automatic bit_xfer(input logic b, input logic collide, output logic rb);
        m_sda = b;
        wait_q(Q);
        scl_up();
        if (collide) begin
            // Bus write lands on the 3rd posedge after the pad rises.
            @(posedge clk);
            @(posedge clk);
            @(negedge clk);
            host_wr_en   = 1'b1;
            host_addr    = 4'd4;
            host_wr_data = 8'hFF;
            @(negedge clk);
            check("collide_aligned", 32'(bus_wr_pulse), 32'd1);
            host_wr_en = 1'b0;
            wait_q(Q - 2);
        end else begin
            wait_q(Q);
        end
        rb = sda_bus;
        wait_q(Q);
        m_scl = 1'b0;
        wait_q(Q);
    endtask

    task automatic start_cond();
        m_sda = 1'b1;
        wait_q(Q);
        scl_up();
        wait_q(Q);
        m_sda = 1'b0;
        wait_q(Q);
        m_scl = 1'b0;
        wait_q(Q);
    endtask

    task automatic stop_cond();
        m_sda = 1'b0;
        wait_q(Q);
        scl_up();
        wait_q(Q);
        m_sda = 1'b1;
        wait_q(Q);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic collide, output logic ack);
        logic rb;
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], collide && (i == 0), rb);
        bit_xfer(1'b1, 1'b0, rb);
        ack = ~rb;
    endtask

    task automatic recv_byte(input logic send_ack);
        logic       rb;
        logic [7:0] d;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bit_xfer(1'b1, 1'b0, rb);
            d = {d[6:0], rb};
        end
        bit_xfer(~send_ack, 1'b0, rb);
        @(posedge clk);
        rx_byte  = d;
        rx_valid = 1'b1;
        @(posedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic host_write(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        host_wr_en   = 1'b1;
        host_addr    = a;
        host_wr_data = d;
        @(negedge clk);
        host_wr_en = 1'b0;
    endtask

    task automatic host_check(input string name, input logic [3:0] a, input logic [7:0] exp);
        @(negedge clk);
        host_addr = a;
        #1;
        check(name, 32'(host_rd_data), 32'(exp));
    endtask

    // Monitor: pops expectations whenever the DUT presents a result.
    always @(negedge clk) begin
        if (bus_wr_pulse) begin
            if (exp_wr.size() == 0) unexpected("bus_wr_pulse");
            else check("bus_wr_addr", 32'(bus_wr_addr), 32'(exp_wr.pop_front()));
        end
        if (done) begin
            if (exp_done == 0) unexpected("done");
            else exp_done--;
        end
        if (rx_valid) begin
            if (exp_rd.size() == 0) unexpected("read_byte");
            else check("read_byte", 32'(rx_byte), 32'(exp_rd.pop_front()));
        end
        if (watch_mm && sda_oen) oen_seen++;
        if (watch_mm && busy) busy_seen++;
        if (scl_oen) begin
            scl_oen_seen++;
            stretch_run++;
        end else if (stretch_run != 0) begin
            stretch_runs.push_back(stretch_run);
            stretch_run = 0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic ack, rb;
        int bad_runs;

        // Reset state
        wait_q(4);
        reset = 1'b0;
        wait_q(1);
        check("rst_sda_oen", 32'(sda_oen), 32'd0);
        check("rst_sda_out", 32'(sda_out), 32'd0);
        check("rst_scl_oen", 32'(scl_oen), 32'd0);
        check("rst_scl_out", 32'(scl_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_wr_pulse", 32'(bus_wr_pulse), 32'd0);
        host_check("rst_reg0", 4'd0, 8'h00);

        // Write: ptr 3, data A5, 5A
        exp_wr.push_back(4'd3);
        exp_wr.push_back(4'd4);
        exp_done++;
        start_cond();
        send_byte(8'hA0, 1'b0, ack);
        check("wr_addr_ack", 32'(ack), 32'd1);
        check("wr_busy", 32'(busy), 32'd1);
        send_byte(8'h03, 1'b0, ack);
        check("wr_ptr_ack", 32'(ack), 32'd1);
        send_byte(8'hA5, 1'b0, ack);
        check("wr_d0_ack", 32'(ack), 32'd1);
        send_byte(8'h5A, 1'b0, ack);
        check("wr_d1_ack", 32'(ack), 32'd1);
        stop_cond();
        wait_q(8);
        check("wr_busy_after", 32'(busy), 32'd0);
        host_check("wr_reg3", 4'd3, 8'hA5);
        host_check("wr_reg4", 4'd4, 8'h5A);
        host_check("wr_reg5", 4'd5, 8'h00);

        // Read across the wrap with a repeated START
        host_write(4'd14, 8'h11);
        host_write(4'd15, 8'h22);
        host_write(4'd0, 8'h33);
        host_write(4'd1, 8'h44);
        exp_rd.push_back(8'h11);
        exp_rd.push_back(8'h22);
        exp_rd.push_back(8'h33);
        exp_done++;
        start_cond();
        send_byte(8'hA0, 1'b0, ack);
        check("rd_addr_ack", 32'(ack), 32'd1);
        send_byte(8'h0E, 1'b0, ack);
        check("rd_ptr_ack", 32'(ack), 32'd1);
        start_cond();
        send_byte(8'hA1, 1'b0, ack);
        check("rd_raddr_ack", 32'(ack), 32'd1);
        recv_byte(1'b1);
        recv_byte(1'b1);
        recv_byte(1'b0);
        stop_cond();
        wait_q(8);

        // Pointer is left at 1; read it back in push-pull mode
        open_drain = 1'b0;
        exp_rd.push_back(8'h44);
        exp_done++;
        start_cond();
        send_byte(8'hA1, 1'b0, ack);
        check("pp_addr_ack", 32'(ack), 32'd1);
        recv_byte(1'b0);
        stop_cond();
        wait_q(8);
        open_drain = 1'b1;

        // Address mismatch
        watch_mm = 1'b1;
        start_cond();
        send_byte(8'hA2, 1'b0, ack);
        check("mm_nack", 32'(ack), 32'd0);
        send_byte(8'h00, 1'b0, ack);
        stop_cond();
        wait_q(8);
        watch_mm = 1'b0;
        check("mm_oen_cycles", 32'(oen_seen), 32'd0);
        check("mm_busy_cycles", 32'(busy_seen), 32'd0);
        host_check("mm_reg3", 4'd3, 8'hA5);

        // Host and bus write the same index in the same cycle
        exp_wr.push_back(4'd4);
        exp_done++;
        start_cond();
        send_byte(8'hA0, 1'b0, ack);
        send_byte(8'h04, 1'b0, ack);
        send_byte(8'h77, 1'b1, ack);
        check("col_ack", 32'(ack), 32'd1);
        stop_cond();
        wait_q(8);
        host_check("col_reg4", 4'd4, 8'h77);

        // Reset while driving bit 3 of 0x33 (a 0, so SDA is pulled)
        start_cond();
        send_byte(8'hA0, 1'b0, ack);
        send_byte(8'h00, 1'b0, ack);
        start_cond();
        send_byte(8'hA1, 1'b0, ack);
        for (int i = 0; i < 4; i++) bit_xfer(1'b1, 1'b0, rb);
        check("mr_driving", 32'(sda_oen), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("mr_sda_oen", 32'(sda_oen), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) host_check("mr_reg_clear", 4'(i), 8'h00);
        exp_wr.push_back(4'd5);
        exp_done++;
        start_cond();
        send_byte(8'hA0, 1'b0, ack);
        check("mr_addr_ack", 32'(ack), 32'd1);
        send_byte(8'h05, 1'b0, ack);
        send_byte(8'hC3, 1'b0, ack);
        stop_cond();
        wait_q(20);
        host_check("mr_reg5", 4'd5, 8'hC3);

        check("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
        check("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
        check("done_drained", 32'(exp_done), 32'd0);
`ifdef I2C_CLK_STRETCH_EN
        bad_runs = 0;
        foreach (stretch_runs[i]) if (stretch_runs[i] != 8) bad_runs++;
        check("stretch_first_len", 32'(stretch_runs.size() > 0 ? stretch_runs[0] : 0), 32'd8);
        check("stretch_bad_runs", 32'(bad_runs), 32'd0);
`else
        bad_runs = stretch_runs.size();
        check("scl_oen_idle", 32'(scl_oen_seen), 32'd0);
        check("scl_oen_runs", 32'(bad_runs), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
